prog_clk_div: RTL and testbench
===============================

PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the divide-ratio and counter.
REQ-002 SHALL have parameter DEF_DIV, default 6: divide ratio in force after reset; legal range 2..2^CNT_W-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge, except REQ-013.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  count enable; 0 freezes all state.
REQ-006 SHALL have port load  input  1  one-cycle request to capture div_ratio.
REQ-007 SHALL have port div_ratio  input  CNT_W  requested divide ratio N.
REQ-008 SHALL have port clk_out  output  1  divided clock, period N clk cycles, 50% duty for even and odd N.
REQ-009 SHALL have port tick  output  1  one-cycle pulse marking the start of each output period.
REQ-010 SHALL have port cfg_err  output  1  one-cycle pulse flagging a rejected load.

Function
REQ-011 SHALL hold an active ratio ratio_q and a counter cnt; each enabled posedge: cnt <= 0 if cnt == ratio_q-1, else cnt+1.
REQ-012 SHALL register pos <= (cnt_next < H) each enabled posedge, H = ceil(ratio_q/2); high phase H cycles, low phase ratio_q-H.
REQ-013 SHALL, for odd ratio_q, retime pos on negedge clk into neg_q and drive clk_out = pos & neg_q (high exactly N/2 cycles); for even ratio_q, clk_out = pos.
REQ-014 SHALL register tick <= en & (cnt == ratio_q-1): tick high in the same cycle clk_out's high phase starts.
REQ-015 SHALL, with en=0, hold cnt, pos, neg_q, ratio_q and pending state unchanged; tick forced 0; clk_out holds level.
REQ-016 SHALL, on load=1 with div_ratio >= 2, store div_ratio in a pending register and set pend_vld; a later load overwrites pending (last write wins).
REQ-017 SHALL, on load=1 with div_ratio < 2, leave pending unchanged and pulse cfg_err for exactly one cycle (registered, next cycle).
REQ-018 SHALL apply pending only at a period boundary: on the enabled edge where cnt == ratio_q-1, ratio_q <= pending, pend_vld <= 0, and H for that edge is computed from the new ratio; no truncated or runt period.
REQ-019 SHALL, when load coincides with a boundary edge, apply the old pending (if any) at that boundary and the new value at the following boundary.
REQ-020 SHALL accept load regardless of en.
REQ-021 SHALL use unsigned arithmetic; cnt never exceeds ratio_q-1; no wrap beyond 2^CNT_W-1.

Reset
REQ-022 SHALL, on posedge with rst_n=0, set ratio_q=DEF_DIV, cnt=DEF_DIV-1, pos=0, pend_vld=0, tick=0, cfg_err=0; neg_q=0 on the next negedge with rst_n=0.
REQ-023 SHALL, after rst_n returns high with en=1, raise clk_out and tick at the first posedge (full first high phase).
REQ-024 SHALL abort any pending ratio and in-progress period on reset mid-operation; no glitch beyond clk_out going low.

Structure
REQ-025 SHALL place CNT_W default, DEF_DIV default and the minimum legal ratio constant (2) in shared package clk_div_pkg.
REQ-026 SHALL implement the negedge retiming stage as sub-module odd_duty_retimer (inputs clk, rst_n, en, pos; output neg_q).

Verification
REQ-027 SHALL cover: 10 ns clk, reset 20 ns, en=1, N=6 -> clk_out period 60 ns, high 30 ns, tick every 60 ns coincident with rising edge.
REQ-028 SHALL cover: load div_ratio=5 -> from next boundary period 50 ns, high exactly 25 ns, low 25 ns.
REQ-029 SHALL cover: N=6, load 4 at cnt=2 -> current 60 ns period completes intact, then 40 ns periods, high 20 ns.
REQ-030 SHALL cover: load div_ratio=1 (and 0) -> cfg_err one 10 ns pulse, period unchanged.
REQ-031 SHALL cover: en low 35 ns mid-high-phase -> clk_out held high, tick absent, phase resumes with remaining count.
REQ-032 SHALL cover: rst_n low 20 ns mid-period with pending load -> clk_out 0, pending discarded, restarts at DEF_DIV with full high phase.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider.
package clk_div_pkg;

  // Default counter / ratio width.
  localparam int CNT_W_DEFAULT   = 8;

  // Divide ratio in force after reset.
  localparam int DEF_DIV_DEFAULT = 6;

  // Smallest ratio that still yields a high and a low phase.
  localparam int MIN_RATIO       = 2;

endpackage

// File: rtl/prog_clk_div_odd_duty_retimer.sv
// Falling-edge retiming of the phase flag, used to trim odd ratios to 50% duty.
module odd_duty_retimer (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic pos,
  output logic neg_q
);

  // Half-cycle delayed copy of pos. While paused, pos is frozen, so the stage only
  // finishes the half-cycle delay of the last enabled edge and then holds its level.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else if (en || (neg_q != pos)) begin
      neg_q <= pos;
    end
  end

endmodule

// File: rtl/prog_clk_div.sv
// Programmable clock divider: period N clk cycles, 50% duty for even and odd N,
// ratio changes deferred to the next period boundary so no runt period appears.
module prog_clk_div
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_ratio,
  output logic             clk_out,
  output logic             tick,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] RATIO_RST = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'(DEF_DIV - 1);
  localparam logic [CNT_W-1:0] RATIO_MIN = CNT_W'(MIN_RATIO);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [CNT_W-1:0] ratio_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] pend_reg;
  logic             pend_vld_reg;
  logic             pos_reg;
  logic             tick_reg;
  logic             cfg_err_reg;

  logic             boundary;
  logic             apply_pend;
  logic             load_ok;
  logic [CNT_W-1:0] ratio_next;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W:0]   half_next;
  logic             pos_next;
  logic             neg_q;

  // Next-state of the period counter; the high-phase length is taken from the
  // ratio that will be active after this edge, so a new ratio starts cleanly.
  always_comb begin
    boundary   = (cnt_reg == (ratio_reg - ONE));
    apply_pend = boundary && pend_vld_reg;
    ratio_next = apply_pend ? pend_reg : ratio_reg;
    cnt_next   = boundary ? '0 : (cnt_reg + ONE);
    // ceil(ratio/2), one bit wider so a full-scale ratio cannot wrap
    half_next  = ({1'b0, ratio_next} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
    pos_next   = ({1'b0, cnt_next} < half_next);
    load_ok    = (div_ratio >= RATIO_MIN);
  end

  // Counter, active ratio and phase flag; all frozen while en is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ratio_reg <= RATIO_RST;
      cnt_reg   <= CNT_RST;
      pos_reg   <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      if (en) begin
        ratio_reg <= ratio_next;
        cnt_reg   <= cnt_next;
        pos_reg   <= pos_next;
      end
      tick_reg <= en & boundary;
    end
  end

  // Pending-ratio capture and rejection flag; loads are accepted even when paused.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_reg     <= RATIO_RST;
      pend_vld_reg <= 1'b0;
      cfg_err_reg  <= 1'b0;
    end else begin
      cfg_err_reg <= load & ~load_ok;
      if (load && load_ok) begin
        // a new request wins over the clear of one consumed at this same boundary
        pend_reg     <= div_ratio;
        pend_vld_reg <= 1'b1;
      end else if (en && apply_pend) begin
        pend_vld_reg <= 1'b0;
      end
    end
  end

  odd_duty_retimer u_retimer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .pos   (pos_reg),
    .neg_q (neg_q)
  );

  // Odd ratios lose the first half cycle of the high phase; even ratios use pos directly.
  assign clk_out = ratio_reg[0] ? (pos_reg & neg_q) : pos_reg;
  assign tick    = tick_reg;
  assign cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_prog_clk_div.sv
// Self-checking bench for prog_clk_div: scoreboard of expected clk_out periods.
module tb_prog_clk_div;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             load = 1'b0;
  logic [CNT_W-1:0] div_ratio = '0;
  logic             clk_out;
  logic             tick;
  logic             cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int period;
    int high;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_on    = 1'b0;
  bit   have_prev = 1'b0;
  time  last_rise = 0;
  time  last_fall = 0;

  prog_clk_div #(.CNT_W(CNT_W), .DEF_DIV(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .div_ratio (div_ratio),
    .clk_out   (clk_out),
    .tick      (tick),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk_out) last_fall = $time;

  // Monitor: each rising edge closes a period and is checked against the scoreboard.
  initial begin : monitor
    exp_t e;
    time  t_now;
    forever begin
      @(posedge clk_out);
      t_now = $time;
      if (mon_on && have_prev && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (int'(t_now - last_rise) !== e.period || int'(last_fall - last_rise) !== e.high) begin
          n_fail++;
          $display("FAIL period_high @%0d: got period %0d high %0d, expected period %0d high %0d",
                   int'(t_now), int'(t_now - last_rise), int'(last_fall - last_rise), e.period, e.high);
        end else begin
          $display("[TB] period ok @%0d: period %0d high %0d", int'(t_now), e.period, e.high);
        end
      end
      last_rise = t_now;
      have_prev = mon_on;
      #1;
      if (mon_on) begin
        n_tests++;
        if (tick !== 1'b1) begin
          n_fail++;
          $display("FAIL tick_at_rise @%0d: got %b, expected 1", int'($time), tick);
        end
      end
    end
  end

  // Expected rise-to-rise time of a period at ratio n_cur followed by ratio n_next:
  // odd ratios rise half a clk cycle after the period start.
  task automatic push_period(input int n_cur, input int n_next);
    exp_t e;
    e.period = n_cur * 10 + ((n_next % 2) ? 5 : 0) - ((n_cur % 2) ? 5 : 0);
    e.high   = n_cur * 5;
    exp_q.push_back(e);
  endtask

  task automatic do_load(input int v);
    div_ratio = CNT_W'(v);
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Align to the first cycle of a period, just past the clk_out rising edge.
  task automatic sync_to_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL sync_tick: got no tick in 300 cycles, expected one");
    end
    #5;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d periods outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0d: got %b, expected %b", name, int'($time), got, want);
    end else begin
      $display("[TB] %s ok @%0d: %b", name, int'($time), got);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    @(posedge clk);
    #1;
    check_bit("reset_clk_out", clk_out, 1'b0);
    check_bit("reset_tick", tick, 1'b0);
    check_bit("reset_cfg_err", cfg_err, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_bit("first_edge_clk_out", clk_out, 1'b1);
    check_bit("first_edge_tick", tick, 1'b1);
  endtask

  task automatic test_div6();
    mon_on = 1'b1;
    sync_to_tick();
    for (int i = 0; i < 4; i++) push_period(6, 6);
    drain("div6");
  endtask

  task automatic test_load_mid();
    sync_to_tick();
    push_period(6, 4);
    for (int i = 0; i < 3; i++) push_period(4, 4);
    repeat (2) @(posedge clk);
    #1;
    do_load(4);
    drain("load_mid");
  endtask

  task automatic test_load5();
    sync_to_tick();
    push_period(4, 5);
    for (int i = 0; i < 3; i++) push_period(5, 5);
    do_load(5);
    check_bit("load5_cfg_err", cfg_err, 1'b0);
    drain("load5");
  endtask

  task automatic test_back_to_back();
    sync_to_tick();
    push_period(5, 8);
    for (int i = 0; i < 2; i++) push_period(8, 8);
    div_ratio = CNT_W'(6);
    load = 1'b1;
    @(posedge clk);
    #1;
    div_ratio = CNT_W'(8);
    @(posedge clk);
    #1;
    load = 1'b0;
    drain("back_to_back");
  endtask

  task automatic test_cfg_err();
    sync_to_tick();
    for (int i = 0; i < 3; i++) push_period(8, 8);
    do_load(1);
    check_bit("cfg_err_ratio1", cfg_err, 1'b1);
    @(posedge clk);
    #1;
    check_bit("cfg_err_ratio1_end", cfg_err, 1'b0);
    do_load(0);
    check_bit("cfg_err_ratio0", cfg_err, 1'b1);
    @(posedge clk);
    #1;
    check_bit("cfg_err_ratio0_end", cfg_err, 1'b0);
    drain("cfg_err");
  endtask

  task automatic test_en_pause();
    exp_t e;
    sync_to_tick();
    @(posedge clk);
    #1;
    en = 1'b0;
    e.period = 110;
    e.high   = 70;
    exp_q.push_back(e);
    push_period(8, 8);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_bit("pause_clk_out", clk_out, 1'b1);
      check_bit("pause_tick", tick, 1'b0);
    end
    #5;
    en = 1'b1;
    drain("en_pause");
  endtask

  task automatic test_reset_mid();
    mon_on = 1'b0;
    sync_to_tick();
    do_load(5);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_bit("mid_reset_clk_out", clk_out, 1'b0);
    check_bit("mid_reset_tick", tick, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_bit("restart_clk_out", clk_out, 1'b1);
    check_bit("restart_tick", tick, 1'b1);
    mon_on = 1'b1;
    for (int i = 0; i < 3; i++) push_period(6, 6);
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_div6();
    test_load_mid();
    test_load5();
    test_back_to_back();
    test_cfg_err();
    test_en_pause();
    test_reset_mid();
    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
